sco_ctrl: RTL and testbench

Control sequencer for the stopwatch datapath. It turns debounced key pulses into run, stop and clear commands for the BCD time counter. It captures lap values into a small record buffer and selects what the display path shows: either the live time or a stored lap. It sits between the key debouncers and the counter / seven-segment encoder inside `sco`.

---
 rtl/sco_pkg.sv | 15 +
 rtl/sco_rec_mem.sv | 23 ++
 rtl/sco_ctrl.sv | 146 ++++++++++++++
 tb/tb_sco_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sco_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
package sco_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_VIEW  = 2'd3
    } sco_state_t;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_DIGITS    = 6;
    localparam int REC_DEPTH_DEF = 8;

endpackage

// File: rtl/sco_rec_mem.sv
// Lap record storage: one synchronous write port, one combinational read port, no data reset.
module sco_rec_mem #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 24,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) r_mem[wr_addr] <= wr_data;
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/sco_ctrl.sv
// Stopwatch control sequencer: key pulses to counter commands, lap capture and display selection.
//   state    | meaning
//   ST_IDLE  | stopped and cleared, counter held
//   ST_RUN   | counting, key_rec captures laps
//   ST_PAUSE | stopped, time retained
//   ST_VIEW  | reviewing laps, returns to r_ret_st
module sco_ctrl
    import sco_pkg::*;
#(
    parameter int REC_DEPTH = REC_DEPTH_DEF,
    parameter int TIME_W    = BCD_DIGIT_W * BCD_DIGITS,
    localparam int IDX_W    = $clog2(REC_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_bs,
    input  logic              key_rec,
    input  logic              key_dis,
    input  logic [TIME_W-1:0] time_bcd,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic [TIME_W-1:0] disp_bcd,
    output logic              disp_src,
    output logic [IDX_W-1:0]  rec_idx,
    output logic [IDX_W:0]    rec_cnt,
    output logic              rec_full
);

    localparam logic [IDX_W:0] C_FULL = (IDX_W+1)'(REC_DEPTH);

    sco_state_t        r_state, w_nxt_state;
    sco_state_t        r_ret_st, w_nxt_ret_st;
    logic [IDX_W-1:0]  r_rec_idx, w_nxt_rec_idx;
    logic [IDX_W:0]    r_rec_cnt, w_nxt_rec_cnt;
    logic              r_cnt_en, r_cnt_clr, r_disp_src, r_rec_full;
    logic [TIME_W-1:0] r_disp_bcd;
    logic              w_nxt_cnt_clr;
    logic              w_wr_en;
    logic [TIME_W-1:0] w_rd_data;
    logic              w_is_full;

    assign w_is_full = (r_rec_cnt == C_FULL);

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_ret_st  = r_ret_st;
        w_nxt_rec_idx = r_rec_idx;
        w_nxt_rec_cnt = r_rec_cnt;
        w_nxt_cnt_clr = 1'b0;
        w_wr_en       = 1'b0;
        // Priority selects a single key; the chosen key may still be a no-op in the current state.
        unique case (r_state)
            ST_IDLE: begin
                if (key_bs) begin
                    w_nxt_state = ST_RUN;
                end else if (!key_rec && key_dis && (r_rec_cnt != '0)) begin
                    w_nxt_state   = ST_VIEW;
                    w_nxt_ret_st  = ST_IDLE;
                    w_nxt_rec_idx = '0;
                end
            end
            ST_RUN: begin
                if (key_bs) begin
                    w_nxt_state = ST_PAUSE;
                end else if (key_rec && !w_is_full) begin
                    w_wr_en       = 1'b1;
                    w_nxt_rec_cnt = r_rec_cnt + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (key_bs) begin
                    w_nxt_state = ST_RUN;
                end else if (key_rec) begin
                    w_nxt_state   = ST_IDLE;
                    w_nxt_cnt_clr = 1'b1;
                    w_nxt_rec_cnt = '0;
                end else if (key_dis && (r_rec_cnt != '0)) begin
                    w_nxt_state   = ST_VIEW;
                    w_nxt_ret_st  = ST_PAUSE;
                    w_nxt_rec_idx = '0;
                end
            end
            ST_VIEW: begin
                if (key_bs) begin
                    w_nxt_state   = r_ret_st;
                    w_nxt_rec_idx = '0;
                end else if (!key_rec && key_dis) begin
                    if (({1'b0, r_rec_idx} + 1'b1) < r_rec_cnt) begin
                        w_nxt_rec_idx = r_rec_idx + 1'b1;
                    end else begin
                        w_nxt_state   = r_ret_st;
                        w_nxt_rec_idx = '0;
                    end
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    sco_rec_mem #(
        .DEPTH (REC_DEPTH),
        .WIDTH (TIME_W),
        .ADDR_W(IDX_W)
    ) u_rec_mem (
        .clk    (clk),
        .wr_en  (w_wr_en),
        .wr_addr(r_rec_cnt[IDX_W-1:0]),
        .wr_data(time_bcd),
        .rd_addr(r_rec_idx),
        .rd_data(w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ret_st   <= ST_IDLE;
            r_rec_idx  <= '0;
            r_rec_cnt  <= '0;
            r_cnt_en   <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_disp_src <= 1'b0;
            r_rec_full <= 1'b0;
            r_disp_bcd <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_ret_st   <= w_nxt_ret_st;
            r_rec_idx  <= w_nxt_rec_idx;
            r_rec_cnt  <= w_nxt_rec_cnt;
            r_cnt_en   <= (w_nxt_state == ST_RUN);
            r_cnt_clr  <= w_nxt_cnt_clr;
            r_disp_src <= (w_nxt_state == ST_VIEW);
            r_rec_full <= (w_nxt_rec_cnt == C_FULL);
            // Follows the already-registered source, giving one cycle of latency from either path.
            r_disp_bcd <= r_disp_src ? w_rd_data : time_bcd;
        end
    end

    assign cnt_en   = r_cnt_en;
    assign cnt_clr  = r_cnt_clr;
    assign disp_bcd = r_disp_bcd;
    assign disp_src = r_disp_src;
    assign rec_idx  = r_rec_idx;
    assign rec_cnt  = r_rec_cnt;
    assign rec_full = r_rec_full;

endmodule

// File: tb/tb_sco_ctrl.sv
// Directed bench for the stopwatch control sequencer.
module tb_sco_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_bs = 1'b0, key_rec = 1'b0, key_dis = 1'b0;
    logic [23:0] time_bcd = '0;
    logic        cnt_en, cnt_clr, disp_src, rec_full;
    logic [23:0] disp_bcd;
    logic [2:0]  rec_idx;
    logic [3:0]  rec_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sco_ctrl #(.REC_DEPTH(8), .TIME_W(24)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_bs  (key_bs),
        .key_rec (key_rec),
        .key_dis (key_dis),
        .time_bcd(time_bcd),
        .cnt_en  (cnt_en),
        .cnt_clr (cnt_clr),
        .disp_bcd(disp_bcd),
        .disp_src(disp_src),
        .rec_idx (rec_idx),
        .rec_cnt (rec_cnt),
        .rec_full(rec_full)
    );

    // One-cycle key pulse; returns 1ns after the edge that sampled it.
    task automatic press(input logic bs, input logic rec, input logic dis);
        @(posedge clk); #1;
        key_bs = bs; key_rec = rec; key_dis = dis;
        @(posedge clk); #1;
        key_bs = 1'b0; key_rec = 1'b0; key_dis = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({cnt_en, cnt_clr, disp_src, rec_full} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {cnt_en, cnt_clr, disp_src, rec_full});
        end
        checks++;
        if ({disp_bcd, rec_idx, rec_cnt} !== '0) begin
            failures++; $display("FAIL reset_values disp=%h idx=%0d cnt=%0d exp all 0", disp_bcd, rec_idx, rec_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_start();
        repeat (9) @(posedge clk);
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (cnt_en !== 1'b1 || disp_src !== 1'b0) begin
            failures++; $display("FAIL start_run cnt_en=%b disp_src=%b exp 1/0", cnt_en, disp_src);
        end
        time_bcd = 24'h000042;
        tick();
        checks++;
        if (disp_bcd !== 24'h000042) begin
            failures++; $display("FAIL start_live got=%h exp=000042", disp_bcd);
        end
        time_bcd = 24'h000043;
        tick();
        checks++;
        if (disp_bcd !== 24'h000043) begin
            failures++; $display("FAIL start_live2 got=%h exp=000043", disp_bcd);
        end
    endtask

    task automatic test_lap();
        time_bcd = 24'h001234;
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (rec_cnt !== 4'd1) begin
            failures++; $display("FAIL lap_cnt1 got=%0d exp=1", rec_cnt);
        end
        time_bcd = 24'h005678;
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (rec_cnt !== 4'd2 || rec_full !== 1'b0) begin
            failures++; $display("FAIL lap_cnt2 got=%0d full=%b exp=2/0", rec_cnt, rec_full);
        end
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (cnt_en !== 1'b0) begin
            failures++; $display("FAIL lap_pause cnt_en=%b exp=0", cnt_en);
        end
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (disp_src !== 1'b1 || rec_idx !== 3'd0) begin
            failures++; $display("FAIL lap_view0 src=%b idx=%0d exp 1/0", disp_src, rec_idx);
        end
        tick();
        checks++;
        if (disp_bcd !== 24'h001234) begin
            failures++; $display("FAIL lap_rec0 got=%h exp=001234", disp_bcd);
        end
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (rec_idx !== 3'd1) begin
            failures++; $display("FAIL lap_idx1 got=%0d exp=1", rec_idx);
        end
        tick();
        checks++;
        if (disp_bcd !== 24'h005678) begin
            failures++; $display("FAIL lap_rec1 got=%h exp=005678", disp_bcd);
        end
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (disp_src !== 1'b0 || rec_idx !== 3'd0 || cnt_en !== 1'b0) begin
            failures++; $display("FAIL lap_exit src=%b idx=%0d en=%b exp 0/0/0", disp_src, rec_idx, cnt_en);
        end
        time_bcd = 24'h000777;
        tick();
        checks++;
        if (disp_bcd !== 24'h000777) begin
            failures++; $display("FAIL lap_live got=%h exp=000777", disp_bcd);
        end
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (cnt_en !== 1'b1) begin
            failures++; $display("FAIL simul_resume cnt_en=%b exp=1", cnt_en);
        end
        time_bcd = 24'h009999;
        press(1'b1, 1'b1, 1'b0);
        checks++;
        if (cnt_en !== 1'b0 || rec_cnt !== 4'd2) begin
            failures++; $display("FAIL simul_bs_rec en=%b cnt=%0d exp 0/2", cnt_en, rec_cnt);
        end
        press(1'b0, 1'b1, 1'b1);
        checks++;
        if (cnt_clr !== 1'b1 || rec_cnt !== 4'd0 || disp_src !== 1'b0) begin
            failures++; $display("FAIL simul_rec_dis clr=%b cnt=%0d src=%b exp 1/0/0", cnt_clr, rec_cnt, disp_src);
        end
    endtask

    task automatic test_clear();
        press(1'b1, 1'b0, 1'b0);
        time_bcd = 24'h000321;
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (rec_cnt !== 4'd1 || cnt_en !== 1'b0) begin
            failures++; $display("FAIL clear_setup cnt=%0d en=%b exp 1/0", rec_cnt, cnt_en);
        end
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (cnt_clr !== 1'b1 || rec_cnt !== 4'd0 || cnt_en !== 1'b0) begin
            failures++; $display("FAIL clear_pulse clr=%b cnt=%0d en=%b exp 1/0/0", cnt_clr, rec_cnt, cnt_en);
        end
        tick();
        checks++;
        if (cnt_clr !== 1'b0) begin
            failures++; $display("FAIL clear_width clr=%b exp=0", cnt_clr);
        end
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (disp_src !== 1'b0) begin
            failures++; $display("FAIL clear_dis_ignored src=%b exp=0", disp_src);
        end
        // A second key_rec in IDLE must not clear again.
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (cnt_clr !== 1'b0) begin
            failures++; $display("FAIL idle_rec_ignored clr=%b exp=0", cnt_clr);
        end
    endtask

    task automatic test_overflow();
        press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            time_bcd = 24'h000100 * (i + 1);
            press(1'b0, 1'b1, 1'b0);
            checks++;
            if (rec_cnt !== ((i < 8) ? 4'(i + 1) : 4'd8) || rec_full !== (i >= 7)) begin
                failures++; $display("FAIL ovf_cnt%0d cnt=%0d full=%b", i, rec_cnt, rec_full);
            end
        end
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (rec_idx !== 3'(k) || disp_bcd !== 24'h000100 * (k + 1)) begin
                failures++; $display("FAIL ovf_rec%0d idx=%0d got=%h exp=%h", k, rec_idx, disp_bcd, 24'h000100 * (k + 1));
            end
            if (k < 7) press(1'b0, 1'b0, 1'b1);
        end
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (disp_src !== 1'b0 || rec_cnt !== 4'd8 || cnt_en !== 1'b0) begin
            failures++; $display("FAIL ovf_exit src=%b cnt=%0d en=%b exp 0/8/0", disp_src, rec_cnt, cnt_en);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        key_dis = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (disp_src !== 1'b1 || rec_idx !== 3'd0) begin
            failures++; $display("FAIL b2b_0 src=%b idx=%0d exp 1/0", disp_src, rec_idx);
        end
        @(posedge clk); #1;
        checks++;
        if (rec_idx !== 3'd1) begin
            failures++; $display("FAIL b2b_1 idx=%0d exp=1", rec_idx);
        end
        @(posedge clk); #1;
        key_dis = 1'b0;
        checks++;
        if (rec_idx !== 3'd2) begin
            failures++; $display("FAIL b2b_2 idx=%0d exp=2", rec_idx);
        end
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (rec_idx !== 3'd2 || disp_src !== 1'b1 || cnt_clr !== 1'b0) begin
            failures++; $display("FAIL view_rec_ignored idx=%0d src=%b clr=%b exp 2/1/0", rec_idx, disp_src, cnt_clr);
        end
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (rec_idx !== 3'd3) begin
            failures++; $display("FAIL b2b_3 idx=%0d exp=3", rec_idx);
        end
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cnt_en, cnt_clr, disp_src, rec_full} !== 4'b0000 || {disp_bcd, rec_idx, rec_cnt} !== '0) begin
            failures++; $display("FAIL reset_mid en=%b clr=%b src=%b full=%b disp=%h idx=%0d cnt=%0d exp all 0",
                                 cnt_en, cnt_clr, disp_src, rec_full, disp_bcd, rec_idx, rec_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (disp_src !== 1'b0 || rec_cnt !== 4'd0) begin
            failures++; $display("FAIL reset_mid_dis src=%b cnt=%0d exp 0/0", disp_src, rec_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_lap();
        test_simultaneous();
        test_clear();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
